// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair: paired TX/RX FIFO for one state machine.
//   TX is pushed by the bus and popped by the SM; RX is pushed by the SM and
//   popped by the bus. Both FIFOs share one 2*DEPTH-word store. Joining lends
//   the other FIFO's half to the owner and disables the donor.
// Ports:
//   clk, rst                  clock, async active-high reset
//   join_tx, join_rx          requested join mode (join_tx wins)
//   flush                     synchronous empty of both FIFOs
//   tx_push/tx_wdata, tx_pop/tx_rdata   TX write (bus) / read (SM)
//   rx_push/rx_wdata, rx_pop/rx_rdata   RX write (SM) / read (bus)
//   tx_/rx_ full, empty, level           status
//   flag_clr, flags           W1C sticky {rx_unf,rx_ovf,tx_unf,tx_ovf}

// Per-FIFO control: pointers, level, status and accept/error strobes.
// Pointers are logical (0..cap-1); the parent adds the storage base.
module pio_fifo_ctl #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          joined,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  output logic          wr,
  output logic          rd,
  output logic          ovf_set,
  output logic          unf_set,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [LW-1:0] lvl_q, cap;
  logic [AW-1:0] last;
  logic          full_i, empty_i, act;

  assign cap     = joined ? LW'(2*DEPTH) : LW'(DEPTH);
  assign last    = AW'(cap - LW'(1));
  assign full_i  = (lvl_q == cap);
  assign empty_i = (lvl_q == '0);

  // Disabled FIFO reads as both full and empty so neither side will use it.
  assign full  = ~en | full_i;
  assign empty = ~en | empty_i;
  assign level = en ? lvl_q : '0;

  assign act     = en & ~clr;
  assign wr      = act & push & ~full_i;
  assign rd      = act & pop  & ~empty_i;
  assign ovf_set = act & push &  full_i;
  assign unf_set = act & pop  &  empty_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (clr) begin
      lvl_q <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (wr) tail <= (tail == last) ? '0 : tail + AW'(1);
      if (rd) head <= (head == last) ? '0 : head + AW'(1);
      if (wr && !rd)      lvl_q <= lvl_q + LW'(1);
      else if (rd && !wr) lvl_q <= lvl_q - LW'(1);
    end
  end
endmodule

module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(2*DEPTH),
  localparam int LW   = $clog2(2*DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             join_tx,
  input  logic             join_rx,
  input  logic             flush,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_wdata,
  input  logic             tx_pop,
  output logic [WIDTH-1:0] tx_rdata,
  input  logic             rx_push,
  input  logic [WIDTH-1:0] rx_wdata,
  input  logic             rx_pop,
  output logic [WIDTH-1:0] rx_rdata,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             rx_full,
  output logic             rx_empty,
  output logic [LW-1:0]    tx_level,
  output logic [LW-1:0]    rx_level,
  input  logic [3:0]       flag_clr,
  output logic [3:0]       flags
);
  // Lane 0 = TX, lane 1 = RX. mode_q[0]: TX joined, mode_q[1]: RX joined.
  logic [1:0]            mode_q, eff_mode;
  logic                  mode_chg, clr;
  logic [1:0]            push_v, pop_v, en_v, wr_v, rd_v, ovf_v, unf_v, full_v, empty_v;
  logic [1:0][WIDTH-1:0] wdata_v, rdata_q;
  logic [1:0][AW-1:0]    head_v, tail_v, base_v, waddr_v, raddr_v;
  logic [1:0][LW-1:0]    level_v;
  logic [3:0]            flags_q;
  logic [WIDTH-1:0]      mem [2*DEPTH];

  assign eff_mode = join_tx ? 2'b01 : (join_rx ? 2'b10 : 2'b00);
  assign mode_chg = (eff_mode != mode_q);
  // A mode change reshapes both FIFOs, so it empties them like a flush.
  assign clr      = flush | mode_chg;

  assign push_v  = {rx_push, tx_push};
  assign pop_v   = {rx_pop, tx_pop};
  assign wdata_v = {rx_wdata, tx_wdata};
  assign en_v    = {~mode_q[0], ~mode_q[1]};
  // RX lives in the upper half unless it owns the whole store.
  assign base_v  = {(mode_q[1] ? AW'(0) : AW'(DEPTH)), AW'(0)};

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    pio_fifo_ctl #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) u_ctl (
      .clk(clk), .rst(rst), .en(en_v[i]), .joined(mode_q[i]), .clr(clr),
      .push(push_v[i]), .pop(pop_v[i]), .wr(wr_v[i]), .rd(rd_v[i]),
      .ovf_set(ovf_v[i]), .unf_set(unf_v[i]), .head(head_v[i]), .tail(tail_v[i]),
      .level(level_v[i]), .full(full_v[i]), .empty(empty_v[i])
    );
    assign waddr_v[i] = base_v[i] + tail_v[i];
    assign raddr_v[i] = base_v[i] + head_v[i];
  end

  // Storage is not reset; writes are held off while rst is asserted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (wr_v[i] && !rst) mem[waddr_v[i]] <= wdata_v[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'b00;
      rdata_q <= '0;
      flags_q <= '0;
    end else begin
      if (mode_chg) mode_q <= eff_mode;
      for (int i = 0; i < 2; i++)
        if (rd_v[i]) rdata_q[i] <= mem[raddr_v[i]];
      // Set wins over a same-cycle clear.
      flags_q <= (flags_q & ~flag_clr) | {unf_v[1], ovf_v[1], unf_v[0], ovf_v[0]};
    end
  end

  assign tx_rdata = rdata_q[0];
  assign rx_rdata = rdata_q[1];
  assign tx_full  = full_v[0];
  assign tx_empty = empty_v[0];
  assign rx_full  = full_v[1];
  assign rx_empty = empty_v[1];
  assign tx_level = level_v[0];
  assign rx_level = level_v[1];
  assign flags    = flags_q;
endmodule

// File: tb/tb_pio_fifo_pair.sv
module tb_pio_fifo_pair;
  localparam int W = 32, D = 4, LW = $clog2(2*D) + 1;

  logic clk = 0, rst = 1;
  logic join_tx = 0, join_rx = 0, flush = 0;
  logic tx_push = 0, tx_pop = 0, rx_push = 0, rx_pop = 0;
  logic [W-1:0] tx_wdata = '0, rx_wdata = '0;
  logic [3:0] flag_clr = '0;
  logic [W-1:0] tx_rdata, rx_rdata;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;
  logic [3:0] flags;

  pio_fifo_pair #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .join_tx(join_tx), .join_rx(join_rx), .flush(flush),
    .tx_push(tx_push), .tx_wdata(tx_wdata), .tx_pop(tx_pop), .tx_rdata(tx_rdata),
    .rx_push(rx_push), .rx_wdata(rx_wdata), .rx_pop(rx_pop), .rx_rdata(rx_rdata),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_level(tx_level), .rx_level(rx_level), .flag_clr(flag_clr), .flags(flags)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: queues per FIFO, mode 0 none / 1 TX joined / 2 RX joined.
  typedef logic [W-1:0] wq_t [$];
  wq_t mq [2];
  int m_mode;
  logic [W-1:0] m_rd [2];
  logic [3:0] m_flags;

  function automatic bit m_en(int i);
    return (i == 0) ? (m_mode != 2) : (m_mode != 1);
  endfunction
  function automatic int m_cap(int i);
    return (m_mode == i + 1) ? 2*D : D;
  endfunction

  task automatic model_reset();
    mq[0].delete(); mq[1].delete();
    m_mode = 0; m_rd[0] = '0; m_rd[1] = '0; m_flags = '0;
  endtask

  task automatic model_step();
    int eff;
    logic [3:0] set;
    logic [1:0] psh, pp;
    logic [W-1:0] wd [2];
    bit do_push, do_pop;
    eff = join_tx ? 1 : (join_rx ? 2 : 0);
    set = '0;
    psh = {rx_push, tx_push}; pp = {rx_pop, tx_pop};
    wd[0] = tx_wdata; wd[1] = rx_wdata;
    if (eff != m_mode) begin
      m_mode = eff; mq[0].delete(); mq[1].delete();
    end else if (flush) begin
      mq[0].delete(); mq[1].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_en(i)) begin
          do_push = 0; do_pop = 0;
          if (psh[i]) begin
            if (mq[i].size() == m_cap(i)) set[2*i] = 1'b1; else do_push = 1;
          end
          if (pp[i]) begin
            if (mq[i].size() == 0) set[2*i+1] = 1'b1; else do_pop = 1;
          end
          if (do_pop) m_rd[i] = mq[i].pop_front();
          if (do_push) mq[i].push_back(wd[i]);
        end
      end
    end
    m_flags = (m_flags & ~flag_clr) | set;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [LW-1:0] el [2];
    logic ef [2], ee [2];
    for (int i = 0; i < 2; i++) begin
      el[i] = m_en(i) ? LW'(mq[i].size()) : '0;
      ef[i] = m_en(i) ? (mq[i].size() == m_cap(i)) : 1'b1;
      ee[i] = m_en(i) ? (mq[i].size() == 0) : 1'b1;
    end
    chk("status", {tx_full, tx_empty, rx_full, rx_empty, tx_level, rx_level},
        {ef[0], ee[0], ef[1], ee[1], el[0], el[1]});
    chk("tx_rdata", tx_rdata, m_rd[0]);
    chk("rx_rdata", rx_rdata, m_rd[1]);
    chk("flags", flags, m_flags);
  endtask

  task automatic idle();
    flush = 0; tx_push = 0; tx_pop = 0; rx_push = 0; rx_pop = 0; flag_clr = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    idle(); join_tx = 0; join_rx = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    check_outputs();
  endtask

  typedef struct {
    logic push, pop;
    logic [W-1:0] wd;
    logic [3:0] clr;
    logic [LW-1:0] lvl;
    logic full, empty;
    logic [W-1:0] rd;
    logic [3:0] fl;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'hA0, 4'h0, 4'd1, 1'b0, 1'b0, 32'h00, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'hA1, 4'h0, 4'd2, 1'b0, 1'b0, 32'h00, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'hA2, 4'h0, 4'd3, 1'b0, 1'b0, 32'h00, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'hA3, 4'h0, 4'd4, 1'b1, 1'b0, 32'h00, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'hA4, 4'h0, 4'd4, 1'b1, 1'b0, 32'h00, 4'h1};
    tbl[5]  = '{1'b0, 1'b1, 32'h00, 4'h0, 4'd3, 1'b0, 1'b0, 32'hA0, 4'h1};
    tbl[6]  = '{1'b0, 1'b1, 32'h00, 4'h0, 4'd2, 1'b0, 1'b0, 32'hA1, 4'h1};
    tbl[7]  = '{1'b0, 1'b1, 32'h00, 4'h0, 4'd1, 1'b0, 1'b0, 32'hA2, 4'h1};
    tbl[8]  = '{1'b0, 1'b1, 32'h00, 4'h0, 4'd0, 1'b0, 1'b1, 32'hA3, 4'h1};
    tbl[9]  = '{1'b0, 1'b1, 32'h00, 4'h0, 4'd0, 1'b0, 1'b1, 32'hA3, 4'h3};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 4'hF, 4'd0, 1'b0, 1'b1, 32'hA3, 4'h0};

    model_reset();
    #12;
    chk("reset", {tx_full, tx_empty, rx_full, rx_empty, tx_level, rx_level, flags},
        {1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'h0});
    chk("reset_rdata", {tx_rdata, rx_rdata}, 64'h0);
    do_reset();

    // Basic TX fill / overflow / drain / underflow / clear.
    for (int k = 0; k < 11; k++) begin
      idle();
      tx_push = tbl[k].push; tx_pop = tbl[k].pop; tx_wdata = tbl[k].wd; flag_clr = tbl[k].clr;
      step();
      chk($sformatf("vec%0d", k), {tx_level, tx_full, tx_empty, tx_rdata, flags},
          {tbl[k].lvl, tbl[k].full, tbl[k].empty, tbl[k].rd, tbl[k].fl});
    end

    // Join TX: 8 entries, RX disabled, FIFO order.
    do_reset();
    join_tx = 1; step();
    for (int k = 0; k < 8; k++) begin
      idle(); tx_push = 1; tx_wdata = 32'hB0 + k; step();
    end
    chk("jtx_full8", {tx_level, tx_full}, {4'd8, 1'b1});
    idle(); rx_push = 1; rx_wdata = 32'h55; step();
    chk("jtx_rx_off", {rx_full, rx_empty, rx_level, flags}, {1'b1, 1'b1, 4'd0, 4'h0});
    for (int k = 0; k < 8; k++) begin
      idle(); tx_pop = 1; step();
      chk("jtx_order", tx_rdata, 32'hB0 + k);
    end

    // Mode change flushes; then RX joined takes 8.
    idle(); join_tx = 0; step();
    for (int k = 0; k < 3; k++) begin
      idle(); tx_push = 1; tx_wdata = 32'hC8 + k; step();
    end
    idle(); join_rx = 1; step();
    chk("modechg_flush", {tx_level, rx_level}, {4'd0, 4'd0});
    for (int k = 0; k < 9; k++) begin
      idle(); rx_push = 1; rx_wdata = 32'hC0 + k; step();
    end
    chk("jrx_full8", {rx_level, rx_full, tx_full, tx_empty, flags},
        {4'd8, 1'b1, 1'b1, 1'b1, 4'b0100});

    // Simultaneous push+pop at full TX and empty RX.
    idle(); join_rx = 0; flag_clr = 4'hF; step();
    for (int k = 0; k < 4; k++) begin
      idle(); tx_push = 1; tx_wdata = 32'hD0 + k; step();
    end
    idle(); tx_push = 1; tx_pop = 1; tx_wdata = 32'hDF; step();
    chk("pp_full", {tx_level, flags[0], tx_rdata}, {4'd3, 1'b1, 32'hD0});
    idle(); rx_push = 1; rx_pop = 1; rx_wdata = 32'hE0; step();
    chk("pp_empty", {rx_level, flags[3]}, {4'd1, 1'b1});

    // Pointer wrap at level 2, then overflow under concurrent clear.
    idle(); flush = 1; flag_clr = 4'hF; step();
    for (int k = 0; k < 2; k++) begin
      idle(); tx_push = 1; tx_wdata = 32'hF0 + k; step();
    end
    for (int k = 0; k < 10; k++) begin
      idle(); tx_push = 1; tx_pop = 1; tx_wdata = 32'hF2 + k; step();
      chk("wrap_order", {tx_level, tx_rdata}, {4'd2, 32'hF0 + k});
    end
    for (int k = 0; k < 2; k++) begin
      idle(); tx_push = 1; tx_wdata = 32'h1F0 + k; step();
    end
    idle(); tx_push = 1; flag_clr = 4'hF; step();
    chk("ovf_over_clr", {flags, tx_level}, {4'h1, 4'd4});

    // Async reset in the middle of a cycle.
    idle(); tx_push = 1; tx_wdata = 32'h77; step();
    @(negedge clk); rst = 1; #1;
    chk("async_rst", {tx_full, tx_empty, tx_level, rx_level, flags, tx_rdata},
        {1'b0, 1'b1, 4'd0, 4'd0, 4'h0, 32'h0});
    idle(); #1 rst = 0;
    model_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) join_tx = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) join_rx = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 39) == 0);
      tx_push  = 1'($urandom_range(0, 1));
      tx_pop   = 1'($urandom_range(0, 1));
      rx_push  = 1'($urandom_range(0, 1));
      rx_pop   = 1'($urandom_range(0, 1));
      tx_wdata = $urandom;
      rx_wdata = $urandom;
      flag_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
